// File: rtl/frame_decoder_if.sv
// Control, SRAM read port and video pins of the frame decoder.
// master = decoder side; slave = encoder/SRAM/display side.
interface frame_decoder_if;
  logic        i_start;
  logic        i_swap_req;
  logic        o_swap_ack;
  logic [19:0] o_sram_addr;
  logic        o_sram_oe;
  logic [15:0] i_sram_data;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_blank_n;
  logic [7:0]  o_r;
  logic [7:0]  o_g;
  logic [7:0]  o_b;
  logic        o_disp_buf;
  logic [31:0] o_frame_counter;

  modport master (
    input  i_start, i_swap_req, i_sram_data,
    output o_swap_ack, o_sram_addr, o_sram_oe, o_hsync, o_vsync, o_blank_n,
           o_r, o_g, o_b, o_disp_buf, o_frame_counter
  );

  modport slave (
    output i_start, i_swap_req, i_sram_data,
    input  o_swap_ack, o_sram_addr, o_sram_oe, o_hsync, o_vsync, o_blank_n,
           o_r, o_g, o_b, o_disp_buf, o_frame_counter
  );
endinterface

// File: rtl/frame_decoder.sv
// VGA raster scan of a double-buffered RGB565 SRAM frame store, swapping buffers in vblank.
// Latency 2 cycles counter-to-pins (colour, sync, blank); no backpressure, fixed pixel-rate fetch.
module frame_decoder #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [19:0] FB0_BASE = 20'd0,
  parameter logic [19:0] FB1_BASE = 20'd307200
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  frame_decoder_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [19:0]   ptr_q, ptr_d;
  logic [31:0]   frame_q, frame_d;
  logic          disp_q, disp_d;
  logic          pend_q, pend_d;
  logic          ack_q;

  logic [19:0]   addr_q;
  logic          oe_q, hs1_q, vs1_q;
  logic          hsync_q, vsync_q, blank_q;
  logic [7:0]    r_q, g_q, b_q;

  logic          active, hs_n, vs_n, line_end, frame_end, swap_pt, swap_fire;
  logic [19:0]   base;
  logic [15:0]   d;

  assign d = bus.i_sram_data;

  always_comb begin
    active    = (h_q < H_ACT) && (v_q < V_ACT);
    hs_n      = !((h_q >= HS_BEG) && (h_q < HS_END));
    vs_n      = !((v_q >= VS_BEG) && (v_q < VS_END));
    line_end  = (h_q == H_LAST);
    frame_end = line_end && (v_q == V_LAST);
    swap_pt   = bus.i_start && (h_q == '0) && (v_q == V_ACT);
    swap_fire = swap_pt && (pend_q || bus.i_swap_req);
    base      = disp_q ? FB1_BASE : FB0_BASE;

    h_d     = h_q;
    v_d     = v_q;
    ptr_d   = ptr_q;
    frame_d = frame_q;
    if (!bus.i_start) begin
      // Idle: park at the origin with the pointer preloaded for a restart.
      h_d   = '0;
      v_d   = '0;
      ptr_d = base;
    end else begin
      h_d = line_end ? '0 : h_q + 1'b1;
      if (line_end) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
      if (frame_end) begin
        ptr_d   = base;
        frame_d = frame_q + 32'd1;
      end else if (active) begin
        ptr_d = ptr_q + 20'd1;
      end
    end

    disp_d = swap_fire ? ~disp_q : disp_q;
    pend_d = swap_fire ? 1'b0 : (pend_q | bus.i_swap_req);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      ptr_q   <= FB0_BASE;
      frame_q <= '0;
      disp_q  <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      addr_q  <= FB0_BASE;
      oe_q    <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      ptr_q   <= ptr_d;
      frame_q <= frame_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      ack_q   <= swap_fire;
      if (!bus.i_start) begin
        addr_q  <= FB0_BASE;
        oe_q    <= 1'b0;
        hs1_q   <= 1'b1;
        vs1_q   <= 1'b1;
        hsync_q <= 1'b1;
        vsync_q <= 1'b1;
        blank_q <= 1'b0;
        r_q     <= '0;
        g_q     <= '0;
        b_q     <= '0;
      end else begin
        addr_q  <= ptr_q;
        oe_q    <= active;
        hs1_q   <= hs_n;
        vs1_q   <= vs_n;
        hsync_q <= hs1_q;
        vsync_q <= vs1_q;
        blank_q <= oe_q;
        // oe_q doubles as the stage-1 active bit; blanked pixels output black.
        r_q     <= oe_q ? {d[15:11], d[15:13]} : 8'd0;
        g_q     <= oe_q ? {d[10:5], d[10:9]}   : 8'd0;
        b_q     <= oe_q ? {d[4:0], d[4:2]}     : 8'd0;
      end
    end
  end

  assign bus.o_swap_ack      = ack_q;
  assign bus.o_sram_addr     = addr_q;
  assign bus.o_sram_oe       = oe_q;
  assign bus.o_hsync         = hsync_q;
  assign bus.o_vsync         = vsync_q;
  assign bus.o_blank_n       = blank_q;
  assign bus.o_r             = r_q;
  assign bus.o_g             = g_q;
  assign bus.o_b             = b_q;
  assign bus.o_disp_buf      = disp_q;
  assign bus.o_frame_counter = frame_q;
endmodule

// File: tb/tb_frame_decoder.sv
// Directed bench: a reduced 15x10 raster (8x6 visible, buffers at 0 and 48) plus a full-size
// instance for the first lines of the 800x525 timing.
module tb_frame_decoder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  frame_decoder_if bus();
  frame_decoder_if bus_f();

  logic [15:0] mem [128];
  assign bus.i_sram_data   = bus.o_sram_oe ? mem[bus.o_sram_addr[6:0]] : 16'hDEAD;
  assign bus_f.i_sram_data = bus_f.o_sram_addr[15:0];

  frame_decoder #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FB0_BASE(20'd0), .FB1_BASE(20'd48)
  ) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  frame_decoder dut_f (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_f));

  int n_cmp = 0;
  int n_bad = 0;
  int exp_frames = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [81:0] got, want;
    rst_n = 1'b0;
    repeat (3) tick;
    got  = {bus.o_sram_addr, bus.o_sram_oe, bus.o_hsync, bus.o_vsync, bus.o_blank_n,
            bus.o_r, bus.o_g, bus.o_b, bus.o_disp_buf, bus.o_swap_ack, bus.o_frame_counter};
    want = {20'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 32'd0};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h", got, want);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick;
      n_cmp++;
      if (bus.o_sram_oe !== 1'b0 || bus.o_hsync !== 1'b1) begin
        n_bad++;
        $display("FAIL idle_cycle%0d: oe=%b hsync=%b want oe=0 hsync=1", i, bus.o_sram_oe, bus.o_hsync);
      end
    end
  endtask

  task automatic test_raster;
    int hs_low, hs_first, vs_low, vs_first, blank_hi, oe_hi, addr_bad, rgb_bad;
    logic [19:0] exp_addr;
    hs_low = 0; hs_first = -1; vs_low = 0; vs_first = -1;
    blank_hi = 0; oe_hi = 0; addr_bad = 0; rgb_bad = 0; exp_addr = 20'd0;
    bus.i_start = 1'b1;
    for (int k = 1; k <= 151; k++) begin
      tick;
      if (bus.o_hsync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (bus.o_vsync === 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = k;
      end
      if (bus.o_blank_n === 1'b1) blank_hi++;
      if (bus.o_blank_n !== 1'b1 && {bus.o_r, bus.o_g, bus.o_b} !== 24'd0) rgb_bad++;
      if (k <= 150 && bus.o_sram_oe === 1'b1) begin
        oe_hi++;
        if (bus.o_sram_addr !== exp_addr) addr_bad++;
        exp_addr = exp_addr + 20'd1;
      end
    end
    exp_frames++;
    n_cmp++; if (hs_first !== 12) begin n_bad++; $display("FAIL hsync_first: got %0d want 12", hs_first); end
    n_cmp++; if (hs_low !== 30) begin n_bad++; $display("FAIL hsync_low_cycles: got %0d want 30", hs_low); end
    n_cmp++; if (vs_first !== 107) begin n_bad++; $display("FAIL vsync_first: got %0d want 107", vs_first); end
    n_cmp++; if (vs_low !== 30) begin n_bad++; $display("FAIL vsync_low_cycles: got %0d want 30", vs_low); end
    n_cmp++; if (blank_hi !== 48) begin n_bad++; $display("FAIL blank_high_cycles: got %0d want 48", blank_hi); end
    n_cmp++; if (oe_hi !== 48) begin n_bad++; $display("FAIL oe_high_cycles: got %0d want 48", oe_hi); end
    n_cmp++; if (addr_bad !== 0) begin n_bad++; $display("FAIL addr_sequence: got %0d wrong want 0", addr_bad); end
    n_cmp++; if (rgb_bad !== 0) begin n_bad++; $display("FAIL rgb_in_blank: got %0d nonzero want 0", rgb_bad); end
    n_cmp++;
    if (bus.o_frame_counter !== 32'(exp_frames)) begin
      n_bad++; $display("FAIL frame_count_raster: got %0d want %0d", bus.o_frame_counter, exp_frames);
    end
    bus.i_start = 1'b0;
    tick;
  endtask

  task automatic test_colour;
    logic [23:0] exp_rgb [5];
    logic [23:0] got;
    exp_rgb[0] = 24'hFF0000; exp_rgb[1] = 24'h00FF00; exp_rgb[2] = 24'h0000FF;
    exp_rgb[3] = 24'h848284; exp_rgb[4] = 24'h000021;
    mem[0] = 16'hF800; mem[1] = 16'h07E0; mem[2] = 16'h001F; mem[3] = 16'h8410;
    bus.i_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick;
      got = {bus.o_r, bus.o_g, bus.o_b};
      if (k == 1) begin
        n_cmp++;
        if (bus.o_blank_n !== 1'b0) begin n_bad++; $display("FAIL blank_cycle1: got %b want 0", bus.o_blank_n); end
      end else if (k <= 6) begin
        n_cmp++;
        if (bus.o_blank_n !== 1'b1 || got !== exp_rgb[k-2]) begin
          n_bad++;
          $display("FAIL colour_px%0d: got blank_n=%b rgb=%h want 1 %h", k - 2, bus.o_blank_n, got, exp_rgb[k-2]);
        end
      end else if (k == 10) begin
        n_cmp++;
        if (bus.o_blank_n !== 1'b0 || got !== 24'd0) begin
          n_bad++; $display("FAIL colour_blanked: got blank_n=%b rgb=%h want 0 000000", bus.o_blank_n, got);
        end
      end
    end
    bus.i_start = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) mem[i] = 16'(i);
  endtask

  task automatic test_swap;
    int n_ack;
    int ack_k [4];
    logic ack_disp [4];
    int exp_k [4];
    logic exp_disp [4];
    exp_k[0] = 91;  exp_k[1] = 241; exp_k[2] = 391; exp_k[3] = 541;
    exp_disp[0] = 1'b1; exp_disp[1] = 1'b0; exp_disp[2] = 1'b1; exp_disp[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin ack_k[i] = -1; ack_disp[i] = 1'bx; end
    n_ack = 0;
    bus.i_start = 1'b1;
    for (int k = 1; k <= 560; k++) begin
      tick;
      bus.i_swap_req = (k == 20 || k == 155 || k == 170 || k == 200 || k == 390 || k == 391);
      if (bus.o_swap_ack === 1'b1) begin
        if (n_ack < 4) begin ack_k[n_ack] = k; ack_disp[n_ack] = bus.o_disp_buf; end
        n_ack++;
      end
      if (k == 151 || k == 301 || k == 451) begin
        n_cmp++;
        if (bus.o_sram_oe !== 1'b1 || bus.o_sram_addr !== ((k == 301) ? 20'd0 : 20'd48)) begin
          n_bad++;
          $display("FAIL swap_first_addr_k%0d: got oe=%b addr=%0d want oe=1 addr=%0d",
                   k, bus.o_sram_oe, bus.o_sram_addr, (k == 301) ? 0 : 48);
        end
      end
    end
    bus.i_swap_req = 1'b0;
    exp_frames += 3;
    n_cmp++;
    if (n_ack !== 4) begin n_bad++; $display("FAIL swap_ack_count: got %0d want 4", n_ack); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ack_k[i] !== exp_k[i] || ack_disp[i] !== exp_disp[i]) begin
        n_bad++;
        $display("FAIL swap_ack%0d: got cycle=%0d disp=%b want cycle=%0d disp=%b",
                 i, ack_k[i], ack_disp[i], exp_k[i], exp_disp[i]);
      end
    end
    n_cmp++;
    if (bus.o_frame_counter !== 32'(exp_frames)) begin
      n_bad++; $display("FAIL frame_count_swap: got %0d want %0d", bus.o_frame_counter, exp_frames);
    end
    bus.i_start = 1'b0;
    tick;
  endtask

  task automatic test_abort_count;
    int ack_at;
    bus.i_start = 1'b1;
    for (int k = 1; k <= 380; k++) begin
      tick;
      bus.i_swap_req = (k == 30 || k == 377);
      if (k == 375) bus.i_start = 1'b0;
      if (k == 300) begin
        n_cmp++;
        if (bus.o_frame_counter !== 32'(exp_frames + 2)) begin
          n_bad++; $display("FAIL two_frames_count: got %0d want %0d", bus.o_frame_counter, exp_frames + 2);
        end
      end
    end
    bus.i_swap_req = 1'b0;
    exp_frames += 2;
    n_cmp++;
    if (bus.o_frame_counter !== 32'(exp_frames) || bus.o_sram_oe !== 1'b0 ||
        bus.o_hsync !== 1'b1 || bus.o_blank_n !== 1'b0 || bus.o_disp_buf !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_idle: got cnt=%0d oe=%b hs=%b blank_n=%b disp=%b want %0d 0 1 0 1",
               bus.o_frame_counter, bus.o_sram_oe, bus.o_hsync, bus.o_blank_n, bus.o_disp_buf, exp_frames);
    end
    ack_at = -1;
    bus.i_start = 1'b1;
    for (int k = 1; k <= 92; k++) begin
      tick;
      if (bus.o_swap_ack === 1'b1) ack_at = k;
      if (k == 1) begin
        n_cmp++;
        if (bus.o_sram_oe !== 1'b1 || bus.o_sram_addr !== 20'd48) begin
          n_bad++; $display("FAIL restart_addr: got oe=%b addr=%0d want oe=1 addr=48", bus.o_sram_oe, bus.o_sram_addr);
        end
      end
    end
    n_cmp++;
    if (ack_at !== 91 || bus.o_disp_buf !== 1'b0) begin
      n_bad++; $display("FAIL pending_kept: got ack_cycle=%0d disp=%b want 91 0", ack_at, bus.o_disp_buf);
    end
    bus.i_start = 1'b0;
    tick;
  endtask

  task automatic test_full_raster;
    int hs_first, hs_low, oe_hi, blank_hi;
    hs_first = -1; hs_low = 0; oe_hi = 0; blank_hi = 0;
    bus_f.i_start = 1'b1;
    for (int k = 1; k <= 801; k++) begin
      tick;
      if (bus_f.o_hsync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (k <= 800 && bus_f.o_sram_oe === 1'b1) oe_hi++;
      if (bus_f.o_blank_n === 1'b1) blank_hi++;
      if (k == 1 || k == 640 || k == 801) begin
        n_cmp++;
        if (bus_f.o_sram_oe !== 1'b1 || bus_f.o_sram_addr !== ((k == 1) ? 20'd0 : (k == 640) ? 20'd639 : 20'd640)) begin
          n_bad++;
          $display("FAIL full_addr_k%0d: got oe=%b addr=%0d want oe=1 addr=%0d", k, bus_f.o_sram_oe,
                   bus_f.o_sram_addr, (k == 1) ? 0 : (k == 640) ? 639 : 640);
        end
      end
    end
    n_cmp++; if (hs_first !== 658) begin n_bad++; $display("FAIL full_hsync_start: got %0d want 658", hs_first); end
    n_cmp++; if (hs_low !== 96) begin n_bad++; $display("FAIL full_hsync_width: got %0d want 96", hs_low); end
    n_cmp++; if (oe_hi !== 640) begin n_bad++; $display("FAIL full_oe_line: got %0d want 640", oe_hi); end
    n_cmp++; if (blank_hi !== 640) begin n_bad++; $display("FAIL full_blank_line: got %0d want 640", blank_hi); end
    bus_f.i_start = 1'b0;
    tick;
  endtask

  task automatic test_reset_midrun;
    logic [81:0] got, want;
    bus.i_start = 1'b1;
    for (int k = 1; k <= 117; k++) begin
      tick;
      bus.i_swap_req = (k == 20);
    end
    n_cmp++;
    if (bus.o_disp_buf !== 1'b1 || bus.o_hsync !== 1'b0 || bus.o_vsync !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_reset_state: got disp=%b hs=%b vs=%b want 1 0 0", bus.o_disp_buf, bus.o_hsync, bus.o_vsync);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got  = {bus.o_sram_addr, bus.o_sram_oe, bus.o_hsync, bus.o_vsync, bus.o_blank_n,
            bus.o_r, bus.o_g, bus.o_b, bus.o_disp_buf, bus.o_swap_ack, bus.o_frame_counter};
    want = {20'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 32'd0};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL midrun_reset_outputs: got %h want %h", got, want);
    end
    bus.i_start = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'(i);
    bus.i_start = 1'b0;
    bus.i_swap_req = 1'b0;
    bus_f.i_start = 1'b0;
    bus_f.i_swap_req = 1'b0;
    rst_n = 1'b0;
    test_reset;
    test_raster;
    test_colour;
    test_swap;
    test_abort_count;
    test_full_raster;
    test_reset_midrun;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
